// File: rtl/fnw_pkg.sv
// Shared definitions for the flip-N-write controller: FSM encoding and counter width.
package fnw_pkg;

  localparam int unsigned BitWritesW = 32;

  typedef logic [1:0] fnw_state_t;

  localparam fnw_state_t StIdle = 2'd0;
  localparam fnw_state_t StRd   = 2'd1;
  localparam fnw_state_t StCmp  = 2'd2;
  localparam fnw_state_t StWr   = 2'd3;

endpackage

// File: rtl/fnw_popcount.sv
// Combinational population count of an N-bit word.
module fnw_popcount #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]       data_i,
  output logic [$clog2(N):0] count_o
);

  // Ripple sum of set bits; N is small so a linear adder chain is acceptable.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + {{$clog2(N){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/fnw_write_ctrl.sv
// Flip-N-write memory controller: each write stores either the data or its complement,
// whichever flips fewer physical bits (flag bit included), and counts the bit changes.
module fnw_write_ctrl
  import fnw_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [AW-1:0]         req_addr,
  input  logic [N-1:0]          req_wdata,
  output logic                  rsp_valid,
  output logic [N-1:0]          rsp_rdata,
  output logic [BitWritesW-1:0] bit_writes
);

  localparam int unsigned PW = $clog2(N) + 1;
  localparam int unsigned CW = $clog2(N) + 2;

  fnw_state_t state_q, state_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [N-1:0]          wdata_q, wdata_d;
  logic                  choose_flip_q, choose_flip_d;
  logic [CW-1:0]         cost_min_q, cost_min_d;
  logic [BitWritesW-1:0] bw_q, bw_d;
  logic [N-1:0]          raw_q [DEPTH];
  logic [N-1:0]          raw_d [DEPTH];
  logic [DEPTH-1:0]      flip_q, flip_d;

  logic [N-1:0]        cur_raw;
  logic                cur_flip;
  logic [PW-1:0]       pc_plain, pc_flip;
  logic [CW-1:0]       cost_plain, cost_flip;
  logic                choose_flip;
  logic [BitWritesW:0] bw_sum;

  assign cur_raw  = raw_q[addr_q];
  assign cur_flip = flip_q[addr_q];

  fnw_popcount #(.N(N)) u_pc_plain (
    .data_i  (cur_raw ^ wdata_q),
    .count_o (pc_plain)
  );

  fnw_popcount #(.N(N)) u_pc_flip (
    .data_i  (cur_raw ^ ~wdata_q),
    .count_o (pc_flip)
  );

  // Cost of each encoding: data bits toggled plus one if the flag must change.
  always_comb begin
    cost_plain  = {1'b0, pc_plain} + {{(CW-1){1'b0}}, cur_flip};
    cost_flip   = {1'b0, pc_flip} + {{(CW-1){1'b0}}, ~cur_flip};
    choose_flip = cost_flip < cost_plain;
    bw_sum      = {1'b0, bw_q} + {{(BitWritesW+1-CW){1'b0}}, cost_min_q};
  end

  // Next-state, request capture, storage update and counter update.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    choose_flip_d = choose_flip_q;
    cost_min_d    = cost_min_q;
    bw_d          = bw_q;
    raw_d         = raw_q;
    flip_d        = flip_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? StCmp : StRd;
        end
      end
      StRd: state_d = StIdle;
      StCmp: begin
        choose_flip_d = choose_flip;
        cost_min_d    = choose_flip ? cost_flip : cost_plain;
        state_d       = StWr;
      end
      StWr: begin
        raw_d[addr_q]  = choose_flip_q ? ~wdata_q : wdata_q;
        flip_d[addr_q] = choose_flip_q;
        bw_d           = bw_sum[BitWritesW] ? '1 : bw_sum[BitWritesW-1:0];
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset clears storage and abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      choose_flip_q <= 1'b0;
      cost_min_q    <= '0;
      bw_q          <= '0;
      flip_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        raw_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      choose_flip_q <= choose_flip_d;
      cost_min_q    <= cost_min_d;
      bw_q          <= bw_d;
      flip_q        <= flip_d;
      raw_q         <= raw_d;
    end
  end

  // Handshake and response outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == StIdle);
    rsp_valid  = (state_q == StRd) || (state_q == StWr);
    rsp_rdata  = (state_q == StRd) ? (cur_raw ^ {N{cur_flip}}) : '0;
    bit_writes = bw_q;
  end

endmodule
